// File: rtl/lzw_pkg.sv
// Shared constants and types for the LZW decompressor.
//   CODE_W / CHAR_W  : code and character widths
//   FIRST_FREE_CODE  : first dictionary code handed out after a (re)start
//   CLEAR_CODE       : dictionary-reset code, only special with LZW_CLEAR_CODE_EN
//   lzw_state_e      : decoder FSM states
//   dict_entry_t     : one prefix/suffix dictionary slot
// Optional feature macro: LZW_CLEAR_CODE_EN (code 256 becomes a clear code).
package lzw_pkg;

    localparam int unsigned CODE_W     = 12;
    localparam int unsigned CHAR_W     = 8;
    localparam int unsigned DICT_SIZE  = 1 << CODE_W;
    localparam int unsigned LIT_LIMIT  = 1 << CHAR_W;
    localparam int unsigned CLEAR_CODE = 256;

`ifdef LZW_CLEAR_CODE_EN
    localparam int unsigned FIRST_FREE_CODE = 257;
`else
    localparam int unsigned FIRST_FREE_CODE = 256;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StWalk,
        StAdd,
        StPop,
        StDone,
        StError
    } lzw_state_e;

    typedef struct packed {
        logic [CODE_W-1:0] prefix;
        logic [CHAR_W-1:0] suffix;
    } dict_entry_t;

endpackage

// File: rtl/lzw_char_stack.sv
// Character LIFO used to reverse a prefix chain into output order.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the stack)
//   push_i       : write data_i on top (ignored when full)
//   pop_i        : drop the top entry (ignored when empty)
//   top_o        : current top entry, combinational
//   empty_o      : no entries held
//   full_o       : Depth entries held
//   level_o      : number of entries held
module lzw_char_stack #(
    parameter int unsigned Depth = 4096,
    parameter int unsigned Width = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           data_i,
    output logic [Width-1:0]           top_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(Depth+1)-1:0] level_o
);
    localparam int unsigned LvlW  = $clog2(Depth + 1);
    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [LvlW-1:0]  level_q;
    logic [AddrW-1:0] top_ptr;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LvlW'(Depth));
    assign level_o = level_q;
    assign top_ptr = level_q[AddrW-1:0] - AddrW'(1);
    assign top_o   = mem_q[top_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= '0;
        end else if (push_i && !full_o) begin
            level_q <= level_q + LvlW'(1);
        end else if (pop_i && !empty_o) begin
            level_q <= level_q - LvlW'(1);
        end
    end

    // Storage carries no reset; only the level pointer defines validity.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i && !full_o) begin
            mem_q[level_q[AddrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/lzw_decoder.sv
// LZW decompressor: 12-bit codes in, 8-bit characters out, dictionary rebuilt on the fly.
//   Clk, Reset           : clock, synchronous active-high reset
//   iCode/iCodeValid/iCodeLast, oCodeReady : code input handshake (ready only when idle)
//   oByte/oByteValid, iByteReady           : character output handshake
//   oDone     : sticky, final code fully emitted
//   oError    : sticky, illegal code received
//   oDictFull : next free code has reached 2**CODE_W
// Optional feature macro: LZW_CLEAR_CODE_EN (code 256 resets the dictionary).
module lzw_decoder
    import lzw_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4096
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [CODE_W-1:0] iCode,
    input  logic              iCodeValid,
    input  logic              iCodeLast,
    output logic              oCodeReady,
    output logic [CHAR_W-1:0] oByte,
    output logic              oByteValid,
    input  logic              iByteReady,
    output logic              oDone,
    output logic              oError,
    output logic              oDictFull
);
    localparam int unsigned       LvlW     = $clog2(STACK_DEPTH + 1);
    localparam logic [CODE_W:0]   NextInit = (CODE_W+1)'(FIRST_FREE_CODE);
    localparam logic [CODE_W:0]   DictEnd  = (CODE_W+1)'(DICT_SIZE);
    localparam logic [CODE_W-1:0] LitEnd   = CODE_W'(LIT_LIMIT);

    lzw_state_e        state_q;
    logic [CODE_W-1:0] cur_q;        // chain walker
    logic [CODE_W-1:0] in_code_q;    // code as accepted, becomes Old after ADD
    logic [CODE_W-1:0] old_q;
    logic [CHAR_W-1:0] first_char_q; // first char of the previous string
    logic [CHAR_W-1:0] new_first_q;  // first char of the string being decoded
    logic              first_flag_q;
    logic              last_pend_q;
    logic [CODE_W:0]   next_code_q;

    dict_entry_t dict_q [DICT_SIZE];
    dict_entry_t cur_entry;

    logic              accept, is_clear, kwkwk, cur_is_lit, dict_we;
    logic [CODE_W:0]   code_ext;
    logic              stack_push, stack_pop, stack_empty, stack_full, pop_last;
    logic [CHAR_W-1:0] stack_din, stack_top;
    logic [LvlW-1:0]   stack_level;

    assign accept     = iCodeValid && (state_q == StIdle);
    assign code_ext   = {1'b0, iCode};
    assign kwkwk      = !first_flag_q && (code_ext == next_code_q);
    assign cur_entry  = dict_q[cur_q];
    assign cur_is_lit = (cur_q < LitEnd);
    assign dict_we    = (state_q == StAdd) && !first_flag_q && (next_code_q < DictEnd);
    assign pop_last   = (stack_level == LvlW'(1));

`ifdef LZW_CLEAR_CODE_EN
    assign is_clear = (iCode == CODE_W'(CLEAR_CODE));
`else
    assign is_clear = 1'b0;
`endif

    // Stack traffic: KwKwK pre-push at accept, one push per WALK cycle, pops on sink handshake.
    always_comb begin
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        stack_din  = '0;
        case (state_q)
            StIdle: begin
                if (accept && !is_clear && kwkwk) begin
                    stack_push = 1'b1;
                    stack_din  = first_char_q;
                end
            end
            StWalk: begin
                stack_push = 1'b1;
                stack_din  = cur_is_lit ? cur_q[CHAR_W-1:0] : cur_entry.suffix;
            end
            StPop:   stack_pop = iByteReady;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            cur_q        <= '0;
            in_code_q    <= '0;
            old_q        <= '0;
            first_char_q <= '0;
            new_first_q  <= '0;
            first_flag_q <= 1'b1;
            last_pend_q  <= 1'b0;
            next_code_q  <= NextInit;
        end else begin
            case (state_q)
                StIdle: begin
                    if (iCodeValid) begin
                        cur_q       <= iCode;
                        in_code_q   <= iCode;
                        last_pend_q <= iCodeLast;
                        if (is_clear) begin
                            next_code_q  <= NextInit;
                            first_flag_q <= 1'b1;
                            state_q      <= iCodeLast ? StDone : StIdle;
                        end else if (first_flag_q && (iCode >= LitEnd)) begin
                            state_q <= StError;
                        end else if (!first_flag_q && (code_ext > next_code_q)) begin
                            state_q <= StError;
                        end else begin
                            // KwKwK: the string is Old plus its own first char.
                            if (kwkwk) begin
                                cur_q <= old_q;
                            end
                            state_q <= StWalk;
                        end
                    end
                end
                StWalk: begin
                    if (cur_is_lit) begin
                        new_first_q <= cur_q[CHAR_W-1:0];
                        state_q     <= StAdd;
                    end else begin
                        cur_q <= cur_entry.prefix;
                    end
                end
                StAdd: begin
                    if (dict_we) begin
                        next_code_q <= next_code_q + (CODE_W+1)'(1);
                    end
                    old_q        <= in_code_q;
                    first_char_q <= new_first_q;
                    first_flag_q <= 1'b0;
                    state_q      <= StPop;
                end
                StPop: begin
                    if (iByteReady && pop_last) begin
                        state_q <= last_pend_q ? StDone : StIdle;
                    end
                end
                StDone:  ;
                StError: ;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Contents survive reset; entries at or above next_code_q are unreachable.
    always_ff @(posedge Clk) begin
        if (!Reset && dict_we) begin
            dict_q[next_code_q[CODE_W-1:0]] <= '{prefix: old_q, suffix: new_first_q};
        end
    end

    lzw_char_stack #(
        .Depth(STACK_DEPTH),
        .Width(CHAR_W)
    ) u_stack (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .push_i (stack_push),
        .pop_i  (stack_pop),
        .data_i (stack_din),
        .top_o  (stack_top),
        .empty_o(stack_empty),
        .full_o (stack_full),
        .level_o(stack_level)
    );

    stack_no_overflow_a: assert property (@(posedge Clk) disable iff (Reset)
        !(stack_push && stack_full));

    assign oCodeReady = (state_q == StIdle);
    assign oByteValid = (state_q == StPop);
    assign oByte      = stack_empty ? '0 : stack_top;
    assign oDone      = (state_q == StDone);
    assign oError     = (state_q == StError);
    assign oDictFull  = (next_code_q == DictEnd);

endmodule

// File: tb/tb_lzw_decoder.sv
// Self-checking bench for lzw_decoder: directed scenarios plus randomized code streams,
// all checked against a string-level LZW reference model.
module tb_lzw_decoder;
    import lzw_pkg::*;

    typedef logic [7:0] bq_t[$];

    localparam int FF = FIRST_FREE_CODE;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [11:0] iCode = '0;
    logic        iCodeValid = 1'b0;
    logic        iCodeLast = 1'b0;
    logic        oCodeReady;
    logic [7:0]  oByte;
    logic        oByteValid;
    logic        iByteReady = 1'b1;
    logic        oDone;
    logic        oError;
    logic        oDictFull;

    always #5 Clk = ~Clk;

    lzw_decoder dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .iCode     (iCode),
        .iCodeValid(iCodeValid),
        .iCodeLast (iCodeLast),
        .oCodeReady(oCodeReady),
        .oByte     (oByte),
        .oByteValid(oByteValid),
        .iByteReady(iByteReady),
        .oDone     (oDone),
        .oError    (oError),
        .oDictFull (oDictFull)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: dictionary holds whole strings.
    bq_t m_dict [4096];
    int  m_next;
    bit  m_first;
    int  m_old;

    task automatic model_reset();
        m_next  = FF;
        m_first = 1'b1;
        m_old   = 0;
    endtask

    function automatic bq_t str_of(input int c);
        bq_t s;
        if (c < 256) s.push_back(8'(c));
        else s = m_dict[c];
        return s;
    endfunction

    task automatic model_decode(input int code, output bq_t out);
        bq_t cur;
        bq_t ent;
        out = {};
`ifdef LZW_CLEAR_CODE_EN
        if (code == 256) begin
            m_next  = 257;
            m_first = 1'b1;
            return;
        end
`endif
        if (m_first || code < m_next) begin
            cur = str_of(code);
        end else begin
            cur = str_of(m_old);
            cur.push_back(cur[0]);
        end
        if (!m_first && m_next < 4096) begin
            ent = str_of(m_old);
            ent.push_back(cur[0]);
            m_dict[m_next] = ent;
            m_next++;
        end
        m_old   = code;
        m_first = 1'b0;
        out     = cur;
    endtask

    task automatic do_reset();
        Reset      = 1'b1;
        iCodeValid = 1'b0;
        iCodeLast  = 1'b0;
        iByteReady = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic send_code(input int code, input bit last);
        int w = 0;
        while (!oCodeReady && w < 50) begin
            @(negedge Clk);
            w++;
        end
        if (!oCodeReady) begin
            check("code_ready_timeout", int'(oCodeReady), 1);
            return;
        end
        iCode      = 12'(code);
        iCodeValid = 1'b1;
        iCodeLast  = last;
        @(negedge Clk);
        iCodeValid = 1'b0;
        iCodeLast  = 1'b0;
    endtask

    // mode 0: always ready, 1: pattern 1,0,0,1 from first valid byte, 2: random
    task automatic collect(input int mode, output bq_t got);
        bit         stalled = 1'b0;
        bit         fin = 1'b0;
        bit         rdy;
        logic [7:0] held = '0;
        int         p = 0;
        got = {};
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!oByteValid && (oCodeReady || oDone || oError)) begin
                fin = 1'b1;
                break;
            end
            if (oByteValid) begin
                check("ready_in_pop", int'(oCodeReady), 0);
                if (stalled) check("byte_hold", int'(oByte), int'(held));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (p % 4 == 0) || (p % 4 == 3);
                default: rdy = 1'($urandom_range(1, 0));
            endcase
            iByteReady = rdy;
            if (oByteValid && rdy) got.push_back(oByte);
            stalled = oByteValid && !rdy;
            held    = oByte;
            if (oByteValid) p++;
            @(negedge Clk);
        end
        iByteReady = 1'b1;
        check("collect_finished", int'(fin), 1);
    endtask

    task automatic cmp_q(input string tag, input bq_t got, input bq_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check({tag, "_byte"}, int'(got[i]), int'(exp[i]));
    endtask

    task automatic run_code(input string tag, input int code, input bit last, input int mode,
                            output bq_t got);
        bq_t exp;
        model_decode(code, exp);
        send_code(code, last);
        collect(mode, got);
        cmp_q(tag, got, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t got, total, want;
        int  waits;
        bit  any_valid;
        int  c;

        // Reset state
        do_reset();
        check("rst_ready", int'(oCodeReady), 1);
        check("rst_valid", int'(oByteValid), 0);
        check("rst_done", int'(oDone), 0);
        check("rst_error", int'(oError), 0);
        check("rst_full", int'(oDictFull), 0);
        check("rst_byte", int'(oByte), 0);
        check("rst_next", int'(dut.next_code_q), FF);

        // A B AB ABA, last code exercises KwKwK
        total = {};
        run_code("abab1", 65, 1'b0, 0, got); total = {total, got};
        run_code("abab2", 66, 1'b0, 0, got); total = {total, got};
        run_code("abab3", FF, 1'b0, 0, got); total = {total, got};
        run_code("abab4", FF + 2, 1'b1, 0, got); total = {total, got};
        want = '{8'd65, 8'd66, 8'd65, 8'd66, 8'd65, 8'd66, 8'd65};
        cmp_q("abab_total", total, want);
        check("abab_done", int'(oDone), 1);
        check("abab_next", int'(dut.next_code_q), FF + 3);

        // Single literal, latency and no add
        do_reset();
        void'(model_decode_dummy());
        send_code(72, 1'b1);
        waits = 0;
        while (!oByteValid && waits < 20) begin
            @(negedge Clk);
            waits++;
        end
        check("lat_waits", waits, 2);
        collect(0, got);
        want = '{8'd72};
        cmp_q("lat", got, want);
        check("lat_done", int'(oDone), 1);
        check("lat_next", int'(dut.next_code_q), FF);

        // Sink stalls
        do_reset();
        total = {};
        run_code("stall1", 65, 1'b0, 1, got); total = {total, got};
        run_code("stall2", 66, 1'b0, 1, got); total = {total, got};
        run_code("stall3", FF, 1'b1, 1, got); total = {total, got};
        want = '{8'd65, 8'd66, 8'd65, 8'd66};
        cmp_q("stall_total", total, want);
        check("stall_done", int'(oDone), 1);

        // Illegal first code, then recovery
        do_reset();
        send_code(300, 1'b0);
        check("err_flag", int'(oError), 1);
        check("err_ready", int'(oCodeReady), 0);
        any_valid  = 1'b0;
        iCode      = 12'd65;
        iCodeValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            any_valid |= oByteValid;
            @(negedge Clk);
        end
        iCodeValid = 1'b0;
        check("err_no_out", int'(any_valid), 0);
        check("err_sticky", int'(oError), 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        check("err_cleared", int'(oError), 0);
        run_code("err_recover", 65, 1'b1, 0, got);
        check("err_recover_done", int'(oDone), 1);

        // Code above NextCode
        do_reset();
        run_code("above1", 65, 1'b0, 0, got);
        send_code(FF + 1, 1'b0);
        check("above_err", int'(oError), 1);

        // Reset in the middle of POP
        do_reset();
        run_code("mid1", 65, 1'b0, 0, got);
        run_code("mid2", 66, 1'b0, 0, got);
        run_code("mid3", FF, 1'b0, 0, got);
        send_code(FF + 2, 1'b0);
        waits = 0;
        while (!oByteValid && waits < 20) begin
            @(negedge Clk);
            waits++;
        end
        check("mid_reached_pop", int'(oByteValid), 1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        check("mid_valid", int'(oByteValid), 0);
        check("mid_ready", int'(oCodeReady), 1);
        check("mid_next", int'(dut.next_code_q), FF);
        run_code("mid_after", 65, 1'b1, 0, got);

`ifdef LZW_CLEAR_CODE_EN
        // Clear code
        do_reset();
        run_code("clr1", 65, 1'b0, 0, got);
        run_code("clr2", 66, 1'b0, 0, got);
        check("clr_next_pre", int'(dut.next_code_q), 258);
        run_code("clr3", 256, 1'b0, 0, got);
        check("clr_next", int'(dut.next_code_q), 257);
        run_code("clr4", 65, 1'b0, 0, got);
        check("clr_next_post", int'(dut.next_code_q), 257);
        run_code("clr5", 256, 1'b1, 0, got);
        check("clr_done", int'(oDone), 1);
`endif

        // Fill the dictionary
        do_reset();
        run_code("fill0", 65, 1'b0, 0, got);
        for (int i = 0; i < 4096 - FF; i++) begin
            if (i == 4096 - FF - 1) check("fill_not_full", int'(oDictFull), 0);
            run_code("fill", int'($urandom_range(255, 0)), 1'b0, 0, got);
        end
        check("fill_full", int'(oDictFull), 1);
        check("fill_next", int'(dut.next_code_q), 4096);
        run_code("full_top", 4095, 1'b0, 0, got);
        check("full_next_hold", int'(dut.next_code_q), 4096);
        check("full_still", int'(oDictFull), 1);

        // Random streams
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int k = 0; k < 40; k++) begin
                if (m_first) c = int'($urandom_range(255, 0));
                else if (m_next < 4096 && $urandom_range(3, 0) == 0) c = m_next;
                else c = int'($urandom_range(m_next - 1, 0));
                run_code("rnd", c, k == 39, 2, got);
            end
            check("rnd_done", int'(oDone), 1);
            check("rnd_next", int'(dut.next_code_q), m_next);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Keeps the model aligned with a code the bench drives by hand.
    function automatic bit model_decode_dummy();
        m_old   = 72;
        m_first = 1'b0;
        return 1'b1;
    endfunction

endmodule
